// File: rtl/round_sequencer.sv
// Game controller for the switch game: arms a prompt, counts down the round,
// judges the player's flip, scores it with tiered points, then runs the break.
module round_sequencer #(
    parameter int ROUND_TIME = 15,
    parameter int BREAK_TIME = 5,
    parameter int ROUND_W    = 7,
    parameter int SCORE_W    = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick_1hz,
    input  logic               sw_event,
    input  logic               sw_match,
    output logic               new_prompt,
    output logic               prompt_en,
    output logic [5:0]         seconds_left,
    output logic [ROUND_W-1:0] round_num,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [2:0]         state_dbg
);

    // Handshake: start, tick_1hz and sw_event are single-cycle pulses with no
    // back-pressure; sw_match is a level that only matters while sw_event is high.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_BREAK = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int          TIER_W   = $clog2(SCORE_W - 1);
    localparam logic [TIER_W-1:0] TIER_MAX = TIER_W'(SCORE_W - 2);
    localparam logic [5:0]  ROUND_T  = 6'(ROUND_TIME);
    localparam logic [5:0]  BREAK_T  = 6'(BREAK_TIME);

    state_t             state;
    logic [2:0]         tier_mod5;
    logic [TIER_W-1:0]  tier;
    logic [SCORE_W-1:0] points;
    logic [SCORE_W:0]   score_sum;

    assign state_dbg = state;
    assign points    = {{(SCORE_W-2){1'b0}}, 2'b10} << tier;
    assign score_sum = {1'b0, score} + {1'b0, points};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            new_prompt   <= 1'b0;
            prompt_en    <= 1'b0;
            game_over    <= 1'b0;
            seconds_left <= '0;
            round_num    <= '0;
            score        <= '0;
            tier_mod5    <= '0;
            tier         <= '0;
        end else begin
            new_prompt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_ARM;
                        new_prompt   <= 1'b1;
                        seconds_left <= ROUND_T;
                    end
                end
                ST_ARM: begin
                    state     <= ST_PLAY;
                    prompt_en <= 1'b1;
                end
                ST_PLAY: begin
                    if (start) begin
                        state        <= ST_ARM;
                        new_prompt   <= 1'b1;
                        prompt_en    <= 1'b0;
                        seconds_left <= ROUND_T;
                        score        <= '0;
                        round_num    <= '0;
                        tier_mod5    <= '0;
                        tier         <= '0;
                    end else if (sw_event && sw_match) begin
                        state        <= ST_BREAK;
                        prompt_en    <= 1'b0;
                        seconds_left <= BREAK_T;
                        score        <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        if (round_num != '1)
                            round_num <= round_num + 1'b1;
                        // Tier advances every fifth pass, after this pass is scored.
                        if (tier_mod5 == 3'd4) begin
                            tier_mod5 <= '0;
                            if (tier != TIER_MAX)
                                tier <= tier + 1'b1;
                        end else begin
                            tier_mod5 <= tier_mod5 + 1'b1;
                        end
                    end else if (sw_event || (tick_1hz && seconds_left == 6'd1)) begin
                        state        <= ST_OVER;
                        prompt_en    <= 1'b0;
                        game_over    <= 1'b1;
                        seconds_left <= '0;
                    end else if (tick_1hz) begin
                        seconds_left <= seconds_left - 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (start) begin
                        state        <= ST_ARM;
                        new_prompt   <= 1'b1;
                        seconds_left <= ROUND_T;
                        score        <= '0;
                        round_num    <= '0;
                        tier_mod5    <= '0;
                        tier         <= '0;
                    end else if (tick_1hz) begin
                        if (seconds_left == 6'd1) begin
                            state        <= ST_ARM;
                            new_prompt   <= 1'b1;
                            seconds_left <= ROUND_T;
                        end else begin
                            seconds_left <= seconds_left - 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state        <= ST_ARM;
                        new_prompt   <= 1'b1;
                        game_over    <= 1'b0;
                        seconds_left <= ROUND_T;
                        score        <= '0;
                        round_num    <= '0;
                        tier_mod5    <= '0;
                        tier         <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
